// File: rtl/pc_chan_pkg.sv
// pc_chan_pkg: FSM state types and the back-off delay shared with the producer/consumer threads.
package pc_chan_pkg;
   localparam int PC_RETRY_DELAY = 32;
   typedef enum logic [1:0] {UP_IDLE, UP_RESP, UP_GAP} up_state_t;
   typedef enum logic [1:0] {DN_IDLE, DN_WAIT, DN_BACKOFF} dn_state_t;
endpackage

// File: rtl/pc_chan_mem.sv
// pc_chan_mem: register-array FIFO storage with wrapping pointers and a level counter.
module pc_chan_mem #(
   parameter int C_DEPTH = 16,
   parameter int C_DWIDTH = 32,
   localparam int C_AW = $clog2(C_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [C_DWIDTH-1:0] wdata,
   output logic [C_DWIDTH-1:0] head,
   output logic [C_AW:0]       level
);
   logic [C_DWIDTH-1:0] mem_q [C_DEPTH];
   logic [C_AW-1:0] wr_q, rd_q;
   logic [C_AW:0] lvl_q;
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= wdata;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_q + C_AW'(push);
         rd_q  <= rd_q + C_AW'(pop);
         lvl_q <= lvl_q + (C_AW+1)'(push) - (C_AW+1)'(pop);
      end
   end
   assign head  = mem_q[rd_q];
   assign level = lvl_q;
endmodule

// File: rtl/pc_chan_fifo.sv
// pc_chan_fifo: buffered producer->consumer channel with back-off retry after a consumer refusal.
// Define PC_CHAN_FIFO_REJECT_EN to answer writes into a full FIFO with in_cerr instead of stalling.
module pc_chan_fifo
   import pc_chan_pkg::*;
#(
   parameter int C_DEPTH = 16,
   parameter int C_DWIDTH = 32,
   parameter int C_RETRY_DELAY = PC_RETRY_DELAY,
   localparam int C_AW = $clog2(C_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_prdy,
   output logic                in_crdy,
   output logic                in_cerr,
   input  logic [C_DWIDTH-1:0] in_data,
   output logic                out_prdy,
   input  logic                out_crdy,
   input  logic                out_cerr,
   output logic [C_DWIDTH-1:0] out_data,
   output logic [C_AW:0]       level,
   output logic [31:0]         rej_cnt
);
   up_state_t up_q, up_d;
   dn_state_t dn_q, dn_d;
   logic in_crdy_q, out_prdy_q, out_prdy_d;
   logic [C_DWIDTH-1:0] out_data_q, out_data_d, head;
   logic [31:0] bo_q, bo_d;
   logic push, pop, full, reject;

   pc_chan_mem #(.C_DEPTH(C_DEPTH), .C_DWIDTH(C_DWIDTH)) u_mem (
      .clk(clk), .rst(rst), .push(push), .pop(pop),
      .wdata(in_data), .head(head), .level(level)
   );

   assign full = level == (C_AW+1)'(C_DEPTH);
   assign push = up_q == UP_IDLE && in_prdy && !full;
   assign pop  = dn_q == DN_WAIT && out_crdy;

`ifdef PC_CHAN_FIFO_REJECT_EN
   logic in_cerr_q;
   logic [31:0] rej_q;
   assign reject = up_q == UP_IDLE && in_prdy && full;
   always_ff @(posedge clk) begin
      if (rst) begin
         in_cerr_q <= 1'b0;
         rej_q     <= '0;
      end else begin
         in_cerr_q <= reject;
         if (reject && rej_q != '1) rej_q <= rej_q + 32'd1;
      end
   end
   assign in_cerr = in_cerr_q;
   assign rej_cnt = rej_q;
`else
   assign reject  = 1'b0;
   assign in_cerr = 1'b0;
   assign rej_cnt = '0;
`endif

   always_comb begin
      up_d = up_q;
      case (up_q)
         UP_IDLE: if (push || reject) up_d = UP_RESP;
         UP_RESP: up_d = UP_GAP;
         default: up_d = UP_IDLE;
      endcase
   end

   // crdy wins over cerr when both arrive together
   always_comb begin
      dn_d       = dn_q;
      out_prdy_d = out_prdy_q;
      out_data_d = out_data_q;
      bo_d       = bo_q;
      case (dn_q)
         DN_IDLE: if (level != '0) begin
            dn_d       = DN_WAIT;
            out_prdy_d = 1'b1;
            out_data_d = head;
         end
         DN_WAIT: if (out_crdy || out_cerr) begin
            out_prdy_d = 1'b0;
            out_data_d = '0;
            if (out_crdy) dn_d = DN_IDLE;
            else begin
               dn_d = DN_BACKOFF;
               bo_d = 32'(C_RETRY_DELAY);
            end
         end
         default: begin
            bo_d = bo_q - 32'd1;
            if (bo_q == 32'd1) dn_d = DN_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         up_q       <= UP_IDLE;
         dn_q       <= DN_IDLE;
         in_crdy_q  <= 1'b0;
         out_prdy_q <= 1'b0;
         out_data_q <= '0;
         bo_q       <= '0;
      end else begin
         up_q       <= up_d;
         dn_q       <= dn_d;
         in_crdy_q  <= push;
         out_prdy_q <= out_prdy_d;
         out_data_q <= out_data_d;
         bo_q       <= bo_d;
      end
   end

   assign in_crdy  = in_crdy_q;
   assign out_prdy = out_prdy_q;
   assign out_data = out_data_q;
endmodule

// File: tb/tb_pc_chan_fifo.sv
// tb_pc_chan_fifo: directed self-checking bench for pc_chan_fifo (default depth 16, retry delay 32).
module tb_pc_chan_fifo;
   logic clk = 1'b0, rst = 1'b1;
   logic in_prdy = 1'b0, out_crdy = 1'b0, out_cerr = 1'b0;
   logic in_crdy, in_cerr, out_prdy;
   logic [31:0] in_data = '0, out_data, rej_cnt;
   logic [4:0] level;
   int checks = 0, passes = 0;

   pc_chan_fifo dut (
      .clk(clk), .rst(rst), .in_prdy(in_prdy), .in_crdy(in_crdy), .in_cerr(in_cerr),
      .in_data(in_data), .out_prdy(out_prdy), .out_crdy(out_crdy), .out_cerr(out_cerr),
      .out_data(out_data), .level(level), .rej_cnt(rej_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic push_word(input logic [31:0] d, output bit ok);
      in_prdy = 1'b1;
      in_data = d;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         ok = in_crdy;
      end
      in_prdy = 1'b0;
   endtask

   task automatic pop_word(input int dly, output logic [31:0] d, output bit ok);
      ok = 1'b0;
      d = '0;
      for (int n = 0; n < 200 && !ok; n++) begin
         if (out_prdy) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         repeat (dly) @(negedge clk);
         d = out_data;
         out_crdy = 1'b1;
         @(negedge clk);
         out_crdy = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++; if ({in_crdy, in_cerr, out_prdy} !== 3'b000) $display("FAIL reset_flags got %b want 000", {in_crdy, in_cerr, out_prdy}); else passes++;
      checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passes++;
      checks++; if (level !== 5'd0) $display("FAIL reset_level got %0d want 0", level); else passes++;
      checks++; if (rej_cnt !== 32'd0) $display("FAIL reset_rej_cnt got %0d want 0", rej_cnt); else passes++;
      @(negedge clk);
      checks++; if (out_prdy !== 1'b0) $display("FAIL reset_idle_prdy got %b want 0", out_prdy); else passes++;
   endtask

   task automatic test_single();
      bit ok;
      push_word(32'hDEAD_BEEF, ok);
      checks++; if (!ok) $display("FAIL single_accept got no in_crdy want pulse"); else passes++;
      checks++; if (level !== 5'd1) $display("FAIL single_level1 got %0d want 1", level); else passes++;
      @(negedge clk);
      checks++; if (in_crdy !== 1'b0) $display("FAIL single_pulse_width got %b want 0", in_crdy); else passes++;
      checks++; if (out_prdy !== 1'b1) $display("FAIL single_latency got %b want 1", out_prdy); else passes++;
      checks++; if (out_data !== 32'hDEAD_BEEF) $display("FAIL single_data got %h want deadbeef", out_data); else passes++;
      out_crdy = 1'b1;
      @(negedge clk);
      out_crdy = 1'b0;
      checks++; if (level !== 5'd0) $display("FAIL single_level0 got %0d want 0", level); else passes++;
      checks++; if ({out_prdy, out_data} !== 33'h0) $display("FAIL single_clear got %b/%h want 0/0", out_prdy, out_data); else passes++;
   endtask

   task automatic test_fill();
      bit ok, got_c, got_e;
      logic [31:0] d;
      int bad = 0;
      for (int i = 0; i < 16; i++) begin
         push_word(32'(i), ok);
         if (!ok) bad++;
      end
      checks++; if (bad != 0) $display("FAIL fill_accepts got %0d timeouts want 0", bad); else passes++;
      checks++; if (level !== 5'd16) $display("FAIL fill_level got %0d want 16", level); else passes++;
      in_prdy = 1'b1;
      in_data = 32'h10;
      got_c = 1'b0;
      got_e = 1'b0;
      for (int n = 0; n < 6 && !got_e; n++) begin
         @(negedge clk);
         got_c |= in_crdy;
         got_e |= in_cerr;
      end
      in_prdy = 1'b0;
      checks++; if (got_c !== 1'b0) $display("FAIL full_crdy got %b want 0", got_c); else passes++;
`ifdef PC_CHAN_FIFO_REJECT_EN
      checks++; if (got_e !== 1'b1) $display("FAIL full_cerr got %b want 1", got_e); else passes++;
      checks++; if (rej_cnt !== 32'd1) $display("FAIL full_rej_cnt got %0d want 1", rej_cnt); else passes++;
`else
      checks++; if (got_e !== 1'b0) $display("FAIL full_cerr got %b want 0", got_e); else passes++;
      checks++; if (rej_cnt !== 32'd0) $display("FAIL full_rej_cnt got %0d want 0", rej_cnt); else passes++;
`endif
      checks++; if (level !== 5'd16) $display("FAIL full_level got %0d want 16", level); else passes++;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         pop_word(0, d, ok);
         checks++; if (!ok || d !== 32'(i)) $display("FAIL drain_%0d got %h (ok=%b) want %h", i, d, ok, i); else passes++;
      end
      checks++; if (level !== 5'd0) $display("FAIL drain_level got %0d want 0", level); else passes++;
   endtask

   task automatic test_cerr();
      bit ok;
      int low = 0;
      logic [31:0] d;
      push_word(32'h5A5A_0001, ok);
      for (int n = 0; n < 20 && !out_prdy; n++) @(negedge clk);
      checks++; if (!ok || out_prdy !== 1'b1) $display("FAIL cerr_offer got %b want 1", out_prdy); else passes++;
      out_cerr = 1'b1;
      @(negedge clk);
      out_cerr = 1'b0;
      while (!out_prdy && low < 100) begin
         low++;
         @(negedge clk);
      end
      checks++; if (low != 33) $display("FAIL cerr_backoff got %0d cycles low want 33", low); else passes++;
      checks++; if (out_data !== 32'h5A5A_0001) $display("FAIL cerr_reoffer got %h want 5a5a0001", out_data); else passes++;
      pop_word(0, d, ok);
      checks++; if (!ok || d !== 32'h5A5A_0001 || level !== 5'd0) $display("FAIL cerr_accept got %h lvl %0d want 5a5a0001 lvl 0", d, level); else passes++;
   endtask

   task automatic test_both();
      bit ok;
      logic [31:0] d;
      push_word(32'h1234_5678, ok);
      for (int n = 0; n < 20 && !out_prdy; n++) @(negedge clk);
      out_crdy = 1'b1;
      out_cerr = 1'b1;
      @(negedge clk);
      out_crdy = 1'b0;
      out_cerr = 1'b0;
      checks++; if (level !== 5'd0) $display("FAIL both_pop got level %0d want 0", level); else passes++;
      push_word(32'h0000_CAFE, ok);
      @(negedge clk);
      checks++; if (!ok || out_prdy !== 1'b1) $display("FAIL both_no_backoff got %b want 1", out_prdy); else passes++;
      pop_word(0, d, ok);
      checks++; if (!ok || d !== 32'h0000_CAFE) $display("FAIL both_next got %h want 0000cafe", d); else passes++;
   endtask

   task automatic test_wrap();
      bit ok_p, ok_c, done = 1'b0;
      int bad_p = 0, bad_c = 0, maxl = 0;
      logic [31:0] d;
      fork
         for (int i = 0; i < 40; i++) begin
            push_word(32'h100 + 32'(i), ok_p);
            if (!ok_p) bad_p++;
         end
         begin
            for (int i = 0; i < 40; i++) begin
               pop_word(int'($urandom_range(7, 0)), d, ok_c);
               if (!ok_c || d !== 32'h100 + 32'(i)) begin
                  bad_c++;
                  $display("FAIL wrap_word_%0d got %h want %h", i, d, 32'h100 + 32'(i));
               end
            end
            done = 1'b1;
         end
         while (!done) begin
            @(negedge clk);
            if (int'(level) > maxl) maxl = int'(level);
         end
      join
      checks++; if (bad_p != 0) $display("FAIL wrap_push got %0d timeouts want 0", bad_p); else passes++;
      checks++; if (bad_c != 0) $display("FAIL wrap_order got %0d bad words want 0", bad_c); else passes++;
      checks++; if (maxl > 16) $display("FAIL wrap_level got max %0d want <=16", maxl); else passes++;
      checks++; if (level !== 5'd0) $display("FAIL wrap_final_level got %0d want 0", level); else passes++;
   endtask

   task automatic test_rst_mid();
      bit ok;
      logic [31:0] d;
      for (int i = 0; i < 5; i++) push_word(32'hA0 + 32'(i), ok);
      @(negedge clk);
      checks++; if (level !== 5'd5 || out_prdy !== 1'b1) $display("FAIL rst_pre got lvl %0d prdy %b want 5 1", level, out_prdy); else passes++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (level !== 5'd0) $display("FAIL rst_level got %0d want 0", level); else passes++;
      checks++; if ({in_crdy, in_cerr, out_prdy} !== 3'b000 || out_data !== 32'h0 || rej_cnt !== 32'd0) $display("FAIL rst_outputs got %b %h %0d want 000 0 0", {in_crdy, in_cerr, out_prdy}, out_data, rej_cnt); else passes++;
      push_word(32'hBEEF_0005, ok);
      pop_word(0, d, ok);
      checks++; if (!ok || d !== 32'hBEEF_0005 || level !== 5'd0) $display("FAIL rst_after got %h lvl %0d want beef0005 lvl 0", d, level); else passes++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_cerr();
      test_both();
      test_wrap();
      test_rst_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
